sfifo_sync_sched: RTL and testbench

- Command sequencer that drains the SYNC_FIFO (16-bit words) once per base-period tick.
- Decodes each word into one of four actions: DOUT set/reset pulses, wait-for-DIN level, wait N cycles, or end-of-period.
- Replaces CPU-polled DOUT writes with tick-aligned hardware sequencing.
- Sits in the wb_clk_i domain between the SYNC_FIFO read port and the GPIO DOUT set/reset lines.

---
 rtl/sfifo_sched_pkg.sv | 29 ++
 rtl/tick_sync_edge.sv | 25 ++
 rtl/sfifo_sync_sched.sv | 180 ++++++++++++++++++
 tb/tb_sfifo_sync_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfifo_sched_pkg.sv
// Shared opcodes, state encoding and command-word field positions for sfifo_sync_sched.
package sfifo_sched_pkg;

    localparam logic [1:0] OP_END      = 2'b00;
    localparam logic [1:0] OP_DOUT     = 2'b01;
    localparam logic [1:0] OP_WAIT_DIN = 2'b10;
    localparam logic [1:0] OP_DELAY    = 2'b11;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StExec    = 3'd2,
        StWaitDin = 3'd3,
        StDelay   = 3'd4
    } sched_state_e;

    localparam int unsigned OpMsb      = 15;
    localparam int unsigned OpLsb      = 14;
    localparam int unsigned DoutValBit = 3;
    localparam int unsigned DoutIdxMsb = 2;
    localparam int unsigned WaitLvlBit = 4;
    localparam int unsigned WaitIdxMsb = 3;
    localparam int unsigned DlyMsb     = 13;

    function automatic logic [7:0] dout_onehot(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; pulse_o is one destination cycle wide.
module tick_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic pulse_o
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= level_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/sfifo_sync_sched.sv
// Tick-aligned command sequencer draining SYNC_FIFO into DOUT set/reset pulses.
// Define SFIFO_SCHED_TMO_EN to add the WAIT_DIN timeout counter and tmo_err_o.
module sfifo_sync_sched
    import sfifo_sched_pkg::*;
#(
    parameter int unsigned SFIFO_DW = 16,
    parameter int unsigned DIN_W    = 16,
    parameter int unsigned TMO_W    = 20
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n_i,
    input  logic                sched_en_i,
    input  logic                sfifo_bp_tick_i,
    input  logic                sfifo_empty_i,
    input  logic [SFIFO_DW-1:0] sfifo_di,
    output logic                sfifo_rd_o,
    input  logic [DIN_W-1:0]    din_i,
    output logic [7:0]          dout_set_o,
    output logic [7:0]          dout_rst_o,
    output logic                busy_o,
    output logic                overrun_o,
    output logic                tmo_err_o,
    output logic [31:0]         period_cnt_o,
    input  logic                clr_i
);

    sched_state_e        state_q, state_d;
    logic [SFIFO_DW-1:0] cmd_q, cmd_d;
    logic [DlyMsb:0]     dly_q, dly_d;
    logic                overrun_q;
    logic [31:0]         period_q;
    logic                period_inc;
    logic                tick_p;
    logic                din_ok;

`ifdef SFIFO_SCHED_TMO_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_err_q;
    logic             tmo_fire;
`else
    logic unused_tmo_w;
    assign unused_tmo_w = |TMO_W;
`endif

    tick_sync_edge u_tick_sync_edge (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n_i),
        .level_i (sfifo_bp_tick_i),
        .pulse_o (tick_p)
    );

    // Indices beyond the DIN width count as already satisfied.
    always_comb begin
        din_ok = 1'b1;
        for (int unsigned i = 0; i < DIN_W; i++) begin
            if (cmd_q[WaitIdxMsb:0] == 4'(i)) begin
                din_ok = (din_i[i] == cmd_q[WaitLvlBit]);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        dly_d      = dly_q;
        sfifo_rd_o = 1'b0;
        dout_set_o = '0;
        dout_rst_o = '0;
        period_inc = 1'b0;
`ifdef SFIFO_SCHED_TMO_EN
        tmo_d      = tmo_q;
        tmo_fire   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (tick_p) state_d = StFetch;
            end
            StFetch: begin
                if (!sfifo_empty_i) begin
                    cmd_d      = sfifo_di;
                    sfifo_rd_o = 1'b1;
                    state_d    = StExec;
                end
            end
            StExec: begin
                unique case (cmd_q[OpMsb:OpLsb])
                    OP_DOUT: begin
                        if (cmd_q[DoutValBit]) dout_set_o = dout_onehot(cmd_q[DoutIdxMsb:0]);
                        else                   dout_rst_o = dout_onehot(cmd_q[DoutIdxMsb:0]);
                        state_d = StFetch;
                    end
                    OP_WAIT_DIN: begin
`ifdef SFIFO_SCHED_TMO_EN
                        tmo_d = '1;
`endif
                        state_d = StWaitDin;
                    end
                    OP_DELAY: begin
                        // N = 0 loads 0, giving the same single stall cycle as N = 1.
                        dly_d = (cmd_q[DlyMsb:0] == '0) ? '0 : cmd_q[DlyMsb:0] - 1'b1;
                        state_d = StDelay;
                    end
                    default: begin
                        period_inc = 1'b1;
                        state_d    = StIdle;
                    end
                endcase
            end
            StWaitDin: begin
                if (din_ok) begin
                    state_d = StFetch;
`ifdef SFIFO_SCHED_TMO_EN
                end else if (tmo_q == '0) begin
                    tmo_fire = 1'b1;
                    state_d  = StFetch;
                end else begin
                    tmo_d = tmo_q - 1'b1;
`endif
                end
            end
            StDelay: begin
                if (dly_q == '0) state_d = StFetch;
                else             dly_d   = dly_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (!sched_en_i) begin
            state_d    = StIdle;
            sfifo_rd_o = 1'b0;
            dout_set_o = '0;
            dout_rst_o = '0;
            period_inc = 1'b0;
`ifdef SFIFO_SCHED_TMO_EN
            tmo_fire   = 1'b0;
`endif
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            dly_q     <= '0;
            overrun_q <= 1'b0;
            period_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            dly_q   <= dly_d;
            // A tick landing while busy is dropped; the flag set beats a clear.
            if (tick_p && (state_q != StIdle)) overrun_q <= 1'b1;
            else if (clr_i)                    overrun_q <= 1'b0;
            if (clr_i)           period_q <= period_inc ? 32'd1 : 32'd0;
            else if (period_inc) period_q <= period_q + 32'd1;
        end
    end

`ifdef SFIFO_SCHED_TMO_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            if (tmo_fire)   tmo_err_q <= 1'b1;
            else if (clr_i) tmo_err_q <= 1'b0;
        end
    end

    assign tmo_err_o = tmo_err_q;
`else
    assign tmo_err_o = 1'b0;
`endif

    assign busy_o       = (state_q != StIdle);
    assign overrun_o    = overrun_q;
    assign period_cnt_o = period_q;

endmodule

// File: tb/tb_sfifo_sync_sched.sv
// Scoreboard bench for sfifo_sync_sched: a queue models the FIFO, expected pulses are queued
// when words are loaded and compared as the DUT emits them.
module tb_sfifo_sync_sched;

`ifdef SFIFO_SCHED_TMO_EN
    localparam int unsigned TmoW = 4;
`else
    localparam int unsigned TmoW = 20;
`endif

    logic        clk = 1'b0;
    logic        wb_rst_n_i;
    logic        sched_en_i;
    logic        sfifo_bp_tick_i;
    logic        sfifo_empty_i;
    logic [15:0] sfifo_di;
    logic        sfifo_rd_o;
    logic [15:0] din_i;
    logic [7:0]  dout_set_o;
    logic [7:0]  dout_rst_o;
    logic        busy_o;
    logic        overrun_o;
    logic        tmo_err_o;
    logic [31:0] period_cnt_o;
    logic        clr_i;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    int          cyc = 0;
    int          pop_cnt = 0;
    int          last_pulse_cyc = 0;
    int          pop_cyc[$];
    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    logic        rd_seen = 1'b0;

    always #5 clk = ~clk;

    sfifo_sync_sched #(
        .SFIFO_DW (16),
        .DIN_W    (16),
        .TMO_W    (TmoW)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_n_i      (wb_rst_n_i),
        .sched_en_i      (sched_en_i),
        .sfifo_bp_tick_i (sfifo_bp_tick_i),
        .sfifo_empty_i   (sfifo_empty_i),
        .sfifo_di        (sfifo_di),
        .sfifo_rd_o      (sfifo_rd_o),
        .din_i           (din_i),
        .dout_set_o      (dout_set_o),
        .dout_rst_o      (dout_rst_o),
        .busy_o          (busy_o),
        .overrun_o       (overrun_o),
        .tmo_err_o       (tmo_err_o),
        .period_cnt_o    (period_cnt_o),
        .clr_i           (clr_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void refresh();
        sfifo_empty_i = (fifo_q.size() == 0);
        sfifo_di      = (fifo_q.size() == 0) ? 16'h0000 : fifo_q[0];
    endfunction

    task automatic push(input logic [15:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_tick();
        sfifo_bp_tick_i = 1'b1;
        step(4);
        sfifo_bp_tick_i = 1'b0;
        step(2);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            step(1);
            n++;
        end
        check_eq({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [15:0] e;
        rd_seen = sfifo_rd_o;
        if (sfifo_rd_o) begin
            pop_cnt++;
            pop_cyc.push_back(cyc);
        end
        if (dout_set_o != 8'h00 || dout_rst_o != 8'h00) begin
            last_pulse_cyc = cyc;
            check_eq("set_rst_exclusive", {31'd0, (dout_set_o != 8'h00 && dout_rst_o != 8'h00)},
                     32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", {16'd0, dout_set_o, dout_rst_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("pulse", {16'd0, dout_set_o, dout_rst_o}, {16'd0, e});
            end
        end
    end

    // FIFO model: pop just after the edge on which the DUT strobed sfifo_rd_o.
    always @(posedge clk) begin
        #1;
        if (rd_seen && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            refresh();
        end
    end

    initial begin
        int p0;
        int rise;
        wb_rst_n_i      = 1'b0;
        sched_en_i      = 1'b1;
        sfifo_bp_tick_i = 1'b0;
        din_i           = '0;
        clr_i           = 1'b0;
        refresh();
        step(3);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_rd", {31'd0, sfifo_rd_o}, 32'd0);
        check_eq("rst_pulses", {16'd0, dout_set_o, dout_rst_o}, 32'd0);
        check_eq("rst_overrun", {31'd0, overrun_o}, 32'd0);
        check_eq("rst_tmo_err", {31'd0, tmo_err_o}, 32'd0);
        check_eq("rst_period", period_cnt_o, 32'd0);
        wb_rst_n_i = 1'b1;
        step(2);

        // DOUT: set bit 5, then reset bit 2, then END.
        p0 = pop_cnt;
        push(16'h400D); push(16'h4002); push(16'h0000);
        exp_q.push_back(16'h2000);
        exp_q.push_back(16'h0004);
        do_tick();
        wait_idle("dout", 100);
        check_eq("dout_pops", pop_cnt - p0, 32'd3);
        check_eq("dout_period", period_cnt_o, 32'd1);
        check_eq("dout_all_pulses", exp_q.size(), 32'd0);

        // WAIT_DIN on din_i[3] == 1, then set bit 0.
        p0 = pop_cnt;
        push(16'h8013); push(16'h4008); push(16'h0000);
        exp_q.push_back(16'h0100);
        do_tick();
        step(50);
        check_eq("wait_stalled", {31'd0, busy_o}, 32'd1);
        check_eq("wait_no_early_pulse", exp_q.size(), 32'd1);
        din_i[3] = 1'b1;
        rise = cyc;
        wait_idle("wait", 20);
        check_eq("wait_pulse_latency", last_pulse_cyc - rise, 32'd2);
        check_eq("wait_tmo_err", {31'd0, tmo_err_o}, 32'd0);
        check_eq("wait_pops", pop_cnt - p0, 32'd3);
        check_eq("wait_period", period_cnt_o, 32'd2);
        din_i = '0;

        // DELAY N=10: pulse lands 12 cycles after the DELAY EXEC (13 after its FETCH).
        pop_cyc.delete();
        push(16'hC00A); push(16'h4009); push(16'h0000);
        exp_q.push_back(16'h0200);
        do_tick();
        wait_idle("delay10", 100);
        check_eq("delay10_latency", last_pulse_cyc - pop_cyc[0], 32'd13);

        // DELAY N=0 behaves as N=1.
        pop_cyc.delete();
        push(16'hC000); push(16'h4009); push(16'h0000);
        exp_q.push_back(16'h0200);
        do_tick();
        wait_idle("delay0", 100);
        check_eq("delay0_latency", last_pulse_cyc - pop_cyc[0], 32'd4);
        check_eq("delay_period", period_cnt_o, 32'd4);

        // Underrun stalls in FETCH; a second tick flags overrun and is dropped.
        p0 = pop_cnt;
        do_tick();
        step(5);
        check_eq("underrun_stall", {31'd0, busy_o}, 32'd1);
        check_eq("underrun_no_pop", pop_cnt - p0, 32'd0);
        check_eq("overrun_clear_before", {31'd0, overrun_o}, 32'd0);
        do_tick();
        check_eq("overrun_set", {31'd0, overrun_o}, 32'd1);
        check_eq("overrun_no_pop", pop_cnt - p0, 32'd0);
        push(16'h0000);
        wait_idle("underrun", 20);
        check_eq("underrun_period", period_cnt_o, 32'd5);
        step(10);
        check_eq("tick_dropped", {31'd0, busy_o}, 32'd0);
        clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        check_eq("clr_overrun", {31'd0, overrun_o}, 32'd0);
        check_eq("clr_period", period_cnt_o, 32'd0);

        // Asynchronous reset in the middle of a long DELAY.
        push(16'hC3FF); push(16'h4009); push(16'h0000);
        do_tick();
        step(10);
        check_eq("mid_delay_busy", {31'd0, busy_o}, 32'd1);
        wb_rst_n_i = 1'b0;
        #1;
        check_eq("async_rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("async_rst_rd", {31'd0, sfifo_rd_o}, 32'd0);
        check_eq("async_rst_pulses", {16'd0, dout_set_o, dout_rst_o}, 32'd0);
        fifo_q.delete();
        refresh();
        step(3);
        wb_rst_n_i = 1'b1;
        p0 = pop_cnt;
        step(10);
        check_eq("post_rst_idle", {31'd0, busy_o}, 32'd0);
        check_eq("post_rst_no_pop", pop_cnt - p0, 32'd0);
        check_eq("post_rst_period", period_cnt_o, 32'd0);

        // WAIT_DIN on din_i[0] == 1 that never comes.
        din_i = '0;
        p0 = pop_cnt;
        push(16'h8010);
`ifdef SFIFO_SCHED_TMO_EN
        push(16'h0000);
        do_tick();
        wait_idle("tmo", 100);
        check_eq("tmo_err_set", {31'd0, tmo_err_o}, 32'd1);
        check_eq("tmo_next_fetched", pop_cnt - p0, 32'd2);
        check_eq("tmo_period", period_cnt_o, 32'd1);
`else
        do_tick();
        step(1000);
        check_eq("wait_forever_busy", {31'd0, busy_o}, 32'd1);
        check_eq("wait_forever_tmo", {31'd0, tmo_err_o}, 32'd0);
        check_eq("wait_forever_pops", pop_cnt - p0, 32'd1);
        sched_en_i = 1'b0;
        step(2);
        check_eq("disable_to_idle", {31'd0, busy_o}, 32'd0);
        sched_en_i = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
